// File: rtl/hazard_forward_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit_if
//   Bundle of the ID-stage decode fields, the branch resolution strobe and the
//   hazard/forwarding results exchanged between the pipeline datapath and the
//   hazard_forward_unit.
//
//   master : pipeline side; drives decode info and br_taken, reads controls.
//   slave  : hazard unit side; reads decode info, drives controls/counters.
//
//   Signals:
//     id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
//     id_reg_write, id_mem_read        ID-stage instruction description
//     br_taken                         branch taken in the resolving stage
//     stall                            hold PC/IF_ID, bubble into ID_EXE
//     flush_if_id/id_exe/exe_mem       clear the named pipeline register
//     fwd_a_sel, fwd_b_sel             EXE operand source selects
//     stall_cnt, flush_cnt             saturating event counters
// ---------------------------------------------------------------------------
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  br_taken;

  logic                  stall;
  logic                  flush_if_id;
  logic                  flush_id_exe;
  logic                  flush_exe_mem;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
           id_reg_write, id_mem_read, br_taken,
    input  stall, flush_if_id, flush_id_exe, flush_exe_mem,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
           id_reg_write, id_mem_read, br_taken,
    output stall, flush_if_id, flush_id_exe, flush_exe_mem,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//   Hazard and forwarding controller for the 5-stage core (IF ID EXE MEM WB).
//   It keeps a private shadow of the EX, MEM and WB stages, built from the
//   ID-stage decode, and from it derives the EXE operand forwarding selects,
//   the load-use stall and the branch flush of the pipeline registers. Stall
//   and flush cycles are counted in saturating counters for perf debug.
//
//   Parameters:
//     REG_ADDR_W  register specifier width
//     BR_STAGE    stage resolving branches: 2 = EXE, 3 = MEM
//     CNT_W       event counter width
//
//   Ports:
//     clock  rising-edge system clock
//     reset  asynchronous active-high reset
//     bus    hazard_forward_unit_if.slave (decode in, controls out)
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int BR_STAGE   = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  hazard_forward_unit_if.slave  bus
);

  typedef logic [REG_ADDR_W-1:0] regAddr_t;

  // EX shadow slot: the only one that keeps source registers
  logic     exValid_q,    exValid_d;
  regAddr_t exRs_q,       exRs_d;
  regAddr_t exRt_q,       exRt_d;
  regAddr_t exDst_q,      exDst_d;
  logic     exRegWrite_q, exRegWrite_d;
  logic     exMemRead_q,  exMemRead_d;

  // MEM shadow slot
  logic     memValid_q,    memValid_d;
  regAddr_t memDst_q,      memDst_d;
  logic     memRegWrite_q, memRegWrite_d;
  logic     memMemRead_q,  memMemRead_d;

  // WB shadow slot; load-ness no longer matters once data is in WB
  logic     wbValid_q,    wbValid_d;
  regAddr_t wbDst_q,      wbDst_d;
  logic     wbRegWrite_q, wbRegWrite_d;

  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic       brTaken;
  logic       flushIdExe;
  logic       flushExeMem;
  logic       loadInEx;
  logic       rsDep;
  logic       rtDep;
  logic       stallHit;
  logic       memSrc;
  logic       wbSrc;
  logic [1:0] fwdA;
  logic [1:0] fwdB;

  // Flushes are masked while reset is asserted so every output reads zero
  // during reset regardless of what the pipeline presents on br_taken.
  assign brTaken     = bus.br_taken & ~reset;
  assign flushIdExe  = brTaken;
  assign flushExeMem = (BR_STAGE == 3) ? brTaken : 1'b0;

  // Load-use: the ID instruction needs a register a load in EX has not yet
  // fetched. A taken branch kills the ID instruction, so it never stalls.
  assign loadInEx = exValid_q & exMemRead_q & (exDst_q != '0);
  assign rsDep    = bus.id_uses_rs & (bus.id_rs == exDst_q);
  assign rtDep    = bus.id_uses_rt & (bus.id_rt == exDst_q);
  assign stallHit = bus.id_valid & loadInEx & (rsDep | rtDep) & ~brTaken;

  // A load sitting in MEM has no data yet, so it is excluded as a MEM
  // source; the one-bubble stall means a consumer never meets it there.
  assign memSrc = memValid_q & memRegWrite_q & ~memMemRead_q & (memDst_q != '0);
  assign wbSrc  = wbValid_q & wbRegWrite_q & (wbDst_q != '0);

  // Operand source selection for the instruction in EX; MEM is younger
  // than WB, so it wins when both hold the same destination.
  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (exValid_q) begin
      if (memSrc && (memDst_q == exRs_q)) begin
        fwdA = 2'b10;
      end else if (wbSrc && (wbDst_q == exRs_q)) begin
        fwdA = 2'b01;
      end
      if (memSrc && (memDst_q == exRt_q)) begin
        fwdB = 2'b10;
      end else if (wbSrc && (wbDst_q == exRt_q)) begin
        fwdB = 2'b01;
      end
    end
  end

  // Shadow pipeline advance. A stalled or flushed ID instruction leaves a
  // fully cleared bubble in EX; a MEM flush clears whatever EX held.
  always_comb begin
    exValid_d     = 1'b0;
    exRs_d        = '0;
    exRt_d        = '0;
    exDst_d       = '0;
    exRegWrite_d  = 1'b0;
    exMemRead_d   = 1'b0;
    if (bus.id_valid && !stallHit && !flushIdExe) begin
      exValid_d    = 1'b1;
      exRs_d       = bus.id_rs;
      exRt_d       = bus.id_rt;
      exDst_d      = bus.id_dst;
      exRegWrite_d = bus.id_reg_write;
      exMemRead_d  = bus.id_mem_read;
    end

    memValid_d    = 1'b0;
    memDst_d      = '0;
    memRegWrite_d = 1'b0;
    memMemRead_d  = 1'b0;
    if (!flushExeMem) begin
      memValid_d    = exValid_q;
      memDst_d      = exDst_q;
      memRegWrite_d = exRegWrite_q;
      memMemRead_d  = exMemRead_q;
    end

    wbValid_d    = memValid_q;
    wbDst_d      = memDst_q;
    wbRegWrite_d = memRegWrite_q;
  end

  // Saturating counters: hold at all-ones instead of wrapping to zero.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (stallHit && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
    if (brTaken && (flushCnt_q != '1)) begin
      flushCnt_d = flushCnt_q + CNT_W'(1);
    end
  end

  // State registers; reset empties every slot at once so forwarding and
  // stall drop in the same cycle reset rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exValid_q     <= 1'b0;
      exRs_q        <= '0;
      exRt_q        <= '0;
      exDst_q       <= '0;
      exRegWrite_q  <= 1'b0;
      exMemRead_q   <= 1'b0;
      memValid_q    <= 1'b0;
      memDst_q      <= '0;
      memRegWrite_q <= 1'b0;
      memMemRead_q  <= 1'b0;
      wbValid_q     <= 1'b0;
      wbDst_q       <= '0;
      wbRegWrite_q  <= 1'b0;
      stallCnt_q    <= '0;
      flushCnt_q    <= '0;
    end else begin
      exValid_q     <= exValid_d;
      exRs_q        <= exRs_d;
      exRt_q        <= exRt_d;
      exDst_q       <= exDst_d;
      exRegWrite_q  <= exRegWrite_d;
      exMemRead_q   <= exMemRead_d;
      memValid_q    <= memValid_d;
      memDst_q      <= memDst_d;
      memRegWrite_q <= memRegWrite_d;
      memMemRead_q  <= memMemRead_d;
      wbValid_q     <= wbValid_d;
      wbDst_q       <= wbDst_d;
      wbRegWrite_q  <= wbRegWrite_d;
      stallCnt_q    <= stallCnt_d;
      flushCnt_q    <= flushCnt_d;
    end
  end

  assign bus.stall         = stallHit;
  assign bus.flush_if_id   = brTaken;
  assign bus.flush_id_exe  = flushIdExe;
  assign bus.flush_exe_mem = flushExeMem;
  assign bus.fwd_a_sel     = fwdA;
  assign bus.fwd_b_sel     = fwdB;
  assign bus.stall_cnt     = stallCnt_q;
  assign bus.flush_cnt     = flushCnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
//   Drives two hazard units from one stimulus stream: index 0 resolves
//   branches in MEM with 16-bit counters, index 1 resolves in EXE with
//   2-bit counters so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clock = ~clock;

  logic       idValid    = 1'b0;
  logic [4:0] idRs       = '0;
  logic [4:0] idRt       = '0;
  logic       idUsesRs   = 1'b0;
  logic       idUsesRt   = 1'b0;
  logic [4:0] idDst      = '0;
  logic       idRegWrite = 1'b0;
  logic       idMemRead  = 1'b0;
  logic       brTaken    = 1'b0;

  int testCount = 0;
  int failCount = 0;

  hazard_forward_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) bus3 ();
  hazard_forward_unit_if #(.REG_ADDR_W(5), .CNT_W(2))  bus2 ();

  assign bus3.id_valid     = idValid;
  assign bus3.id_rs        = idRs;
  assign bus3.id_rt        = idRt;
  assign bus3.id_uses_rs   = idUsesRs;
  assign bus3.id_uses_rt   = idUsesRt;
  assign bus3.id_dst       = idDst;
  assign bus3.id_reg_write = idRegWrite;
  assign bus3.id_mem_read  = idMemRead;
  assign bus3.br_taken     = brTaken;

  assign bus2.id_valid     = idValid;
  assign bus2.id_rs        = idRs;
  assign bus2.id_rt        = idRt;
  assign bus2.id_uses_rs   = idUsesRs;
  assign bus2.id_uses_rt   = idUsesRt;
  assign bus2.id_dst       = idDst;
  assign bus2.id_reg_write = idRegWrite;
  assign bus2.id_mem_read  = idMemRead;
  assign bus2.br_taken     = brTaken;

  hazard_forward_unit #(.REG_ADDR_W(5), .BR_STAGE(3), .CNT_W(16)) dutBr3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  hazard_forward_unit #(.REG_ADDR_W(5), .BR_STAGE(2), .CNT_W(2)) dutBr2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  // Observed outputs gathered per configuration, counters zero-extended
  logic        stallO  [2];
  logic        fIfId   [2];
  logic        fIdExe  [2];
  logic        fExeMem [2];
  logic [1:0]  fwdA    [2];
  logic [1:0]  fwdB    [2];
  logic [15:0] cntS    [2];
  logic [15:0] cntF    [2];

  assign stallO[0]  = bus3.stall;
  assign stallO[1]  = bus2.stall;
  assign fIfId[0]   = bus3.flush_if_id;
  assign fIfId[1]   = bus2.flush_if_id;
  assign fIdExe[0]  = bus3.flush_id_exe;
  assign fIdExe[1]  = bus2.flush_id_exe;
  assign fExeMem[0] = bus3.flush_exe_mem;
  assign fExeMem[1] = bus2.flush_exe_mem;
  assign fwdA[0]    = bus3.fwd_a_sel;
  assign fwdA[1]    = bus2.fwd_a_sel;
  assign fwdB[0]    = bus3.fwd_b_sel;
  assign fwdB[1]    = bus2.fwd_b_sel;
  assign cntS[0]    = bus3.stall_cnt;
  assign cntS[1]    = {14'b0, bus2.stall_cnt};
  assign cntF[0]    = bus3.flush_cnt;
  assign cntF[1]    = {14'b0, bus2.flush_cnt};

  // Reference model: an array of in-flight instructions, index 0 = EX,
  // 1 = MEM, 2 = WB, per configuration.
  typedef struct {
    bit valid;
    int rs;
    int rt;
    int dst;
    bit rw;
    bit mr;
  } slot_t;

  slot_t pipe [2][3];
  int    mCntStall  [2];
  int    mCntFlush  [2];
  int    cfgBrStage [2] = '{3, 2};
  int    cfgCntMax  [2] = '{65535, 3};

  function automatic slot_t emptySlot();
    slot_t s;
    s.valid = 1'b0;
    s.rs    = 0;
    s.rt    = 0;
    s.dst   = 0;
    s.rw    = 1'b0;
    s.mr    = 1'b0;
    return s;
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) pipe[c][k] = emptySlot();
      mCntStall[c] = 0;
      mCntFlush[c] = 0;
    end
  endfunction

  // The ID instruction must wait if a load in EX produces a register it reads
  function automatic bit modelStall(int c);
    bit needs;
    needs = (idUsesRs && int'(idRs) == pipe[c][0].dst) ||
            (idUsesRt && int'(idRt) == pipe[c][0].dst);
    return idValid && pipe[c][0].valid && pipe[c][0].mr &&
           pipe[c][0].dst != 0 && needs && !brTaken;
  endfunction

  // Youngest older producer of srcReg wins; a load still in MEM cannot supply
  function automatic logic [1:0] modelFwd(int c, int srcReg);
    if (!pipe[c][0].valid) return 2'b00;
    for (int k = 1; k < 3; k++) begin
      if (pipe[c][k].valid && pipe[c][k].rw && pipe[c][k].dst != 0 &&
          pipe[c][k].dst == srcReg && !(k == 1 && pipe[c][k].mr))
        return (k == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic applyStimulus(input bit v, input int rs, input int rt,
                               input bit ur, input bit ut, input int dst,
                               input bit rw, input bit mr, input bit br);
    idValid    = v;
    idRs       = 5'(rs);
    idRt       = 5'(rt);
    idUsesRs   = ur;
    idUsesRt   = ut;
    idDst      = 5'(dst);
    idRegWrite = rw;
    idMemRead  = mr;
    brTaken    = br;
  endtask

  // One clock: model next state is taken from pre-edge inputs, then the
  // edge, then a settle delay so checks sample away from the edge.
  task automatic advance();
    slot_t nxt [2][3];
    int    nS [2];
    int    nF [2];
    for (int c = 0; c < 2; c++) begin
      bit st;
      st = modelStall(c);
      nxt[c][2] = pipe[c][1];
      nxt[c][1] = (brTaken && cfgBrStage[c] == 3) ? emptySlot() : pipe[c][0];
      if (idValid && !st && !brTaken) begin
        nxt[c][0].valid = 1'b1;
        nxt[c][0].rs    = int'(idRs);
        nxt[c][0].rt    = int'(idRt);
        nxt[c][0].dst   = int'(idDst);
        nxt[c][0].rw    = idRegWrite;
        nxt[c][0].mr    = idMemRead;
      end else begin
        nxt[c][0] = emptySlot();
      end
      nS[c] = (st && mCntStall[c] < cfgCntMax[c]) ? mCntStall[c] + 1 : mCntStall[c];
      nF[c] = (brTaken && mCntFlush[c] < cfgCntMax[c]) ? mCntFlush[c] + 1 : mCntFlush[c];
    end
    @(posedge clock);
    if (reset) begin
      modelReset();
    end else begin
      pipe      = nxt;
      mCntStall = nS;
      mCntFlush = nF;
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      advance();
    end
  endtask

  // Reset state, then a reset landing mid-stream with a load-use pending
  task automatic test_reset();
    modelReset();
    #2;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if ({stallO[c], fIfId[c], fIdExe[c], fExeMem[c], fwdA[c], fwdB[c], cntS[c], cntF[c]} !== 40'h0) begin
        failCount++;
        $display("[TB] FAIL reset_initial dut%0d: got %h expected 0", c,
                 {stallO[c], fIfId[c], fIdExe[c], fExeMem[c], fwdA[c], fwdB[c], cntS[c], cntF[c]});
      end
    end
    @(posedge clock);
    #1;
    reset = 1'b0;

    applyStimulus(1, 1, 0, 1, 0, 2, 1, 1, 0);
    advance();
    applyStimulus(1, 2, 1, 1, 1, 5, 1, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (stallO[c] !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL reset_pre_stall dut%0d: got %b expected 1", c, stallO[c]);
      end
    end

    for (int phase = 0; phase < 3; phase++) begin
      if (phase == 0) begin
        reset = 1'b1;
        modelReset();
        #1;
      end else if (phase == 1) begin
        advance();
      end else begin
        reset = 1'b0;
        #1;
      end
      for (int c = 0; c < 2; c++) begin
        testCount++;
        if ({stallO[c], fIfId[c], fIdExe[c], fExeMem[c], fwdA[c], fwdB[c], cntS[c], cntF[c]} !== 40'h0) begin
          failCount++;
          $display("[TB] FAIL reset_midstream_p%0d dut%0d: got %h expected 0", phase, c,
                   {stallO[c], fIfId[c], fIdExe[c], fExeMem[c], fwdA[c], fwdB[c], cntS[c], cntF[c]});
        end
      end
    end
    advance();
    drain();
  endtask

  // add r3 immediately followed by add r4,r3,r5
  task automatic test_forward_mem();
    drain();
    applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0);
    advance();
    applyStimulus(1, 3, 5, 1, 1, 4, 1, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (fwdA[c] !== 2'b10 || fwdB[c] !== 2'b00 || stallO[c] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL fwd_mem dut%0d: got a=%b b=%b stall=%b expected a=10 b=00 stall=0",
                 c, fwdA[c], fwdB[c], stallO[c]);
      end
    end
    advance();
  endtask

  // add r3; nop; sub r6,r7,r3  then  add r3; add r3; sub r6,r3,r3
  task automatic test_forward_wb_priority();
    drain();
    applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(1, 7, 3, 1, 1, 6, 1, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (fwdA[c] !== 2'b00 || fwdB[c] !== 2'b01) begin
        failCount++;
        $display("[TB] FAIL fwd_wb dut%0d: got a=%b b=%b expected a=00 b=01", c, fwdA[c], fwdB[c]);
      end
    end
    advance();

    drain();
    applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0);
    advance();
    applyStimulus(1, 1, 2, 1, 1, 3, 1, 0, 0);
    advance();
    applyStimulus(1, 3, 3, 1, 1, 6, 1, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (fwdA[c] !== 2'b10 || fwdB[c] !== 2'b10) begin
        failCount++;
        $display("[TB] FAIL fwd_priority dut%0d: got a=%b b=%b expected a=10 b=10", c, fwdA[c], fwdB[c]);
      end
    end
    advance();
  endtask

  // lw r2; and r5,r2,r1  then the same pair targeting r0
  task automatic test_load_use();
    drain();
    applyStimulus(1, 1, 0, 1, 0, 2, 1, 1, 0);
    advance();
    applyStimulus(1, 2, 1, 1, 1, 5, 1, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (stallO[c] !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL load_use_stall dut%0d: got %b expected 1", c, stallO[c]);
      end
    end
    advance();
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (stallO[c] !== 1'b0 || cntS[c] !== 16'd1 || fwdA[c] !== 2'b00 || fwdB[c] !== 2'b00) begin
        failCount++;
        $display("[TB] FAIL load_use_bubble dut%0d: got stall=%b cnt=%0d a=%b b=%b expected stall=0 cnt=1 a=00 b=00",
                 c, stallO[c], cntS[c], fwdA[c], fwdB[c]);
      end
    end
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (fwdA[c] !== 2'b01 || fwdB[c] !== 2'b00 || stallO[c] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL load_use_fwd dut%0d: got a=%b b=%b stall=%b expected a=01 b=00 stall=0",
                 c, fwdA[c], fwdB[c], stallO[c]);
      end
    end
    advance();

    drain();
    applyStimulus(1, 1, 0, 1, 0, 0, 1, 1, 0);
    advance();
    applyStimulus(1, 0, 1, 1, 1, 5, 1, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (stallO[c] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL load_r0_stall dut%0d: got %b expected 0", c, stallO[c]);
      end
    end
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (fwdA[c] !== 2'b00 || fwdB[c] !== 2'b00) begin
        failCount++;
        $display("[TB] FAIL load_r0_fwd dut%0d: got a=%b b=%b expected 00 00", c, fwdA[c], fwdB[c]);
      end
    end
    advance();
  endtask

  // Taken branch coinciding with a load-use condition
  task automatic test_branch_flush();
    drain();
    applyStimulus(1, 1, 0, 1, 0, 2, 1, 1, 0);
    advance();
    applyStimulus(1, 2, 1, 1, 1, 5, 1, 0, 1);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (fIfId[c] !== 1'b1 || fIdExe[c] !== 1'b1 || fExeMem[c] !== (c == 0) || stallO[c] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL branch_flush dut%0d: got if_id=%b id_exe=%b exe_mem=%b stall=%b expected 1 1 %b 0",
                 c, fIfId[c], fIdExe[c], fExeMem[c], stallO[c], (c == 0));
      end
    end
    advance();
    applyStimulus(1, 2, 1, 1, 1, 5, 1, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (cntF[c] !== 16'd1 || stallO[c] !== 1'b0 || fExeMem[c] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL branch_after dut%0d: got flush_cnt=%0d stall=%b exe_mem=%b expected 1 0 0",
                 c, cntF[c], stallO[c], fExeMem[c]);
      end
    end
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (fwdA[c] !== ((c == 0) ? 2'b00 : 2'b01)) begin
        failCount++;
        $display("[TB] FAIL branch_mem_bubble dut%0d: got a=%b expected %b",
                 c, fwdA[c], ((c == 0) ? 2'b00 : 2'b01));
      end
    end
    advance();
  endtask

  // Four consecutive taken branches, then a would-be load-use afterwards
  task automatic test_back_to_back();
    drain();
    applyStimulus(1, 1, 0, 1, 0, 2, 1, 1, 0);
    advance();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2, 1, 1, 1, 5, 1, 0, 1);
      #1;
      for (int c = 0; c < 2; c++) begin
        testCount++;
        if (fIfId[c] !== 1'b1 || fIdExe[c] !== 1'b1 || fExeMem[c] !== (c == 0) || stallO[c] !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL b2b_flush%0d dut%0d: got if_id=%b id_exe=%b exe_mem=%b stall=%b expected 1 1 %b 0",
                   i, c, fIfId[c], fIdExe[c], fExeMem[c], stallO[c], (c == 0));
        end
      end
      advance();
    end
    applyStimulus(1, 2, 1, 1, 1, 5, 1, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (stallO[c] !== 1'b0 || cntF[c] !== ((c == 0) ? 16'd5 : 16'd3)) begin
        failCount++;
        $display("[TB] FAIL b2b_after dut%0d: got stall=%b flush_cnt=%0d expected 0 %0d",
                 c, stallO[c], cntF[c], (c == 0) ? 5 : 3);
      end
    end
    advance();
  endtask

  // Five more load-use stalls: the 2-bit counter must stick at 3
  task automatic test_saturation();
    drain();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 1, 0, 2, 1, 1, 0);
      advance();
      applyStimulus(1, 2, 1, 1, 1, 5, 1, 0, 0);
      #1;
      for (int c = 0; c < 2; c++) begin
        testCount++;
        if (stallO[c] !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL sat_stall%0d dut%0d: got %b expected 1", i, c, stallO[c]);
        end
      end
      advance();
      advance();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int c = 0; c < 2; c++) begin
      testCount++;
      if (cntS[c] !== ((c == 0) ? 16'd6 : 16'd3)) begin
        failCount++;
        $display("[TB] FAIL sat_stall_cnt dut%0d: got %0d expected %0d", c, cntS[c], (c == 0) ? 6 : 3);
      end
    end
    advance();
  endtask

  // Random instruction stream on a small register set against the model
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit rw;
      v  = ($urandom_range(0, 3) != 0);
      rw = $urandom_range(0, 1) == 1;
      applyStimulus(v, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 3)), rw,
                    rw && ($urandom_range(0, 2) == 0), $urandom_range(0, 7) == 0);
      #1;
      for (int c = 0; c < 2; c++) begin
        logic       eStall;
        logic [1:0] eA;
        logic [1:0] eB;
        eStall = modelStall(c);
        eA     = modelFwd(c, pipe[c][0].rs);
        eB     = modelFwd(c, pipe[c][0].rt);
        testCount++;
        if (stallO[c] !== eStall) begin
          failCount++;
          $display("[TB] FAIL rnd_stall cyc%0d dut%0d: got %b expected %b", i, c, stallO[c], eStall);
        end
        testCount++;
        if (fIfId[c] !== brTaken || fIdExe[c] !== brTaken ||
            fExeMem[c] !== (brTaken && cfgBrStage[c] == 3)) begin
          failCount++;
          $display("[TB] FAIL rnd_flush cyc%0d dut%0d: got %b%b%b expected %b%b%b", i, c,
                   fIfId[c], fIdExe[c], fExeMem[c], brTaken, brTaken, (brTaken && cfgBrStage[c] == 3));
        end
        testCount++;
        if (fwdA[c] !== eA) begin
          failCount++;
          $display("[TB] FAIL rnd_fwd_a cyc%0d dut%0d: got %b expected %b", i, c, fwdA[c], eA);
        end
        testCount++;
        if (fwdB[c] !== eB) begin
          failCount++;
          $display("[TB] FAIL rnd_fwd_b cyc%0d dut%0d: got %b expected %b", i, c, fwdB[c], eB);
        end
        testCount++;
        if (cntS[c] !== 16'(mCntStall[c]) || cntF[c] !== 16'(mCntFlush[c])) begin
          failCount++;
          $display("[TB] FAIL rnd_counters cyc%0d dut%0d: got %0d/%0d expected %0d/%0d", i, c,
                   cntS[c], cntF[c], mCntStall[c], mCntFlush[c]);
        end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_forward_mem();
    test_forward_wb_priority();
    test_load_use();
    test_branch_flush();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
